// File: rtl/phy_rx_lane_deserializer_if.sv
// Lane-side bundle between the serial receiver and the byte-assembly stage.
// The master drives the serial bit; the slave returns aligned bytes and lock status.
interface phy_rx_lane_deserializer_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       com_out;
  logic       active_out;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  com_out,
    input  active_out
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output com_out,
    output active_out
  );
endinterface

// File: rtl/phy_rx_lane_deserializer.sv
// Per-lane serial-to-byte deserializer: hunts for COM bitwise, locks after SYNC_COM
// consecutive aligned COMs, then delivers aligned non-COM bytes and flags idles.
module phy_rx_lane_deserializer #(
  parameter logic [7:0]  COM_SYMBOL = 8'hBC,
  parameter int unsigned SYNC_COM   = 4
) (
  input  logic                        clk_32f,
  input  logic                        reset,
  phy_rx_lane_deserializer_if.slave   lane
);

  localparam logic [3:0] SYNC_CNT = 4'(SYNC_COM);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    SYNCED = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [6:0] shift_reg, shift_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [3:0] com_cnt, com_cnt_nxt;
  logic [7:0] data_p1, data_nxt;
  logic       vld_p1, vld_nxt;
  logic       com_p1, com_nxt;
  logic       active_p1, active_nxt;

  logic [7:0] window;
  logic       boundary;
  logic       win_is_com;

  function automatic logic is_com(input logic [7:0] byte_val);
    return byte_val == COM_SYMBOL;
  endfunction

  // Stage p0: combinational window of the seven held bits plus the bit arriving now
  assign window     = {shift_reg, lane.data_in};
  assign boundary   = (bit_cnt == 3'd7);
  assign win_is_com = is_com(window);

  always_comb begin
    state_nxt   = state;
    shift_nxt   = window[6:0];
    bit_cnt_nxt = bit_cnt + 3'd1;
    com_cnt_nxt = com_cnt;
    data_nxt    = data_p1;
    vld_nxt     = 1'b0;
    com_nxt     = 1'b0;
    active_nxt  = active_p1;

    unique case (state)
      HUNT: begin
        if (win_is_com) begin
          bit_cnt_nxt = 3'd0;
          com_nxt     = 1'b1;
          com_cnt_nxt = 4'd1;
          if (SYNC_COM == 1) begin
            state_nxt  = SYNCED;
            active_nxt = 1'b1;
          end else begin
            state_nxt  = ALIGN;
          end
        end
      end

      ALIGN: begin
        if (boundary) begin
          if (win_is_com) begin
            com_nxt     = 1'b1;
            com_cnt_nxt = com_cnt + 4'd1;
            if (com_cnt + 4'd1 == SYNC_CNT) begin
              state_nxt  = SYNCED;
              active_nxt = 1'b1;
            end
          end else begin
            // Misaligned byte: restart the bitwise search from the next edge
            state_nxt   = HUNT;
            com_cnt_nxt = 4'd0;
          end
        end
      end

      SYNCED: begin
        // Lock is sticky; a COM straddling bytes is never looked for here
        if (boundary) begin
          data_nxt = window;
          if (win_is_com) com_nxt = 1'b1;
          else            vld_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = HUNT;
      end
    endcase
  end

  // Stage p1: registered state and outputs, visible the cycle after the 8th bit
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state     <= HUNT;
      shift_reg <= '0;
      bit_cnt   <= '0;
      com_cnt   <= '0;
      data_p1   <= '0;
      vld_p1    <= 1'b0;
      com_p1    <= 1'b0;
      active_p1 <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_cnt   <= bit_cnt_nxt;
      com_cnt   <= com_cnt_nxt;
      data_p1   <= data_nxt;
      vld_p1    <= vld_nxt;
      com_p1    <= com_nxt;
      active_p1 <= active_nxt;
    end
  end

  assign lane.data_out   = data_p1;
  assign lane.valid_out  = vld_p1;
  assign lane.com_out    = com_p1;
  assign lane.active_out = active_p1;

endmodule

// File: tb/tb_phy_rx_lane_deserializer.sv
// Bench for phy_rx_lane_deserializer: directed scenarios with literal expectations,
// then randomized serial streams checked every cycle against a bit-history model.
module tb_phy_rx_lane_deserializer;

  localparam logic [7:0] COM = 8'hBC;
  localparam int         NSYNC = 4;

  localparam int M_HUNT  = 0;
  localparam int M_ALIGN = 1;
  localparam int M_LOCK  = 2;

  logic clk_32f = 1'b0;
  logic reset   = 1'b1;

  phy_rx_lane_deserializer_if lane();

  phy_rx_lane_deserializer #(
    .COM_SYMBOL (COM),
    .SYNC_COM   (NSYNC)
  ) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .lane    (lane)
  );

  always #5 clk_32f = ~clk_32f;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model state: every bit since the last reset, absolute bit index of
  // the last accepted COM, and the expected registered outputs.
  bit         hist[$];
  int         mode;
  int         anchor;
  int         coms;
  logic [7:0] exp_data;
  logic       exp_valid, exp_com, exp_active;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] last_byte();
    logic [7:0] w;
    int n;
    n = hist.size();
    w = '0;
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = n - 8 + k;
      w[7-k] = (idx >= 0) ? hist[idx] : 1'b0;
    end
    return w;
  endfunction

  task automatic model_update(input bit b, input bit r);
    logic [7:0] w;
    int n;
    if (r) begin
      hist.delete();
      mode = M_HUNT; anchor = 0; coms = 0;
      exp_data = 8'h00; exp_valid = 1'b0; exp_com = 1'b0; exp_active = 1'b0;
      return;
    end
    hist.push_back(b);
    n = hist.size();
    w = last_byte();
    exp_valid = 1'b0;
    exp_com   = 1'b0;
    if (mode == M_HUNT) begin
      if (w == COM) begin
        anchor  = n;
        coms    = 1;
        exp_com = 1'b1;
        if (NSYNC == 1) begin mode = M_LOCK; exp_active = 1'b1; end
        else mode = M_ALIGN;
      end
    end else if (((n - anchor) % 8) == 0) begin
      if (mode == M_LOCK) begin
        exp_data = w;
        if (w == COM) exp_com = 1'b1;
        else          exp_valid = 1'b1;
      end else if (w == COM) begin
        exp_com = 1'b1;
        coms++;
        if (coms == NSYNC) begin mode = M_LOCK; exp_active = 1'b1; end
      end else begin
        mode = M_HUNT;
        coms = 0;
      end
    end
  endtask

  // Drive one bit on the falling edge, let the DUT sample it, then advance the model.
  task automatic step(input bit b, input bit r);
    @(negedge clk_32f);
    lane.data_in = b;
    reset        = r;
    @(posedge clk_32f);
    #1;
    model_update(b, r);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(v[i], 1'b0);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b1);
  endtask

  always @(negedge clk_32f) begin
    if (chk_en) begin
      check("data_out",   lane.data_out,   exp_data);
      check("valid_out",  {7'd0, lane.valid_out},  {7'd0, exp_valid});
      check("com_out",    {7'd0, lane.com_out},    {7'd0, exp_com});
      check("active_out", {7'd0, lane.active_out}, {7'd0, exp_active});
      check("valid_com_exclusive", {7'd0, lane.valid_out & lane.com_out}, 8'd0);
    end
  end

  initial begin
    lane.data_in = 1'b0;
    model_update(1'b0, 1'b1);

    // Reset state
    do_reset(2);
    chk_en = 1'b1;
    check("rst_data",   lane.data_out, 8'h00);
    check("rst_flags",  {5'd0, lane.valid_out, lane.com_out, lane.active_out}, 8'd0);

    // Lock on four COMs; active rises with the 32nd bit
    for (int i = 0; i < 3; i++) begin
      send_byte(COM);
      check("lock_com_pulse", {7'd0, lane.com_out}, 8'd1);
      check("lock_not_active", {7'd0, lane.active_out}, 8'd0);
    end
    send_byte(COM);
    check("lock_active", {7'd0, lane.active_out}, 8'd1);
    check("lock_model_active", {7'd0, exp_active}, 8'd1);
    check("lock_no_valid", {7'd0, lane.valid_out}, 8'd0);

    // Data after lock
    send_byte(8'hAA); check("data_aa0", lane.data_out, 8'hAA); check("vld_aa0", {7'd0, lane.valid_out}, 8'd1);
    send_byte(8'hAA); check("data_aa1", lane.data_out, 8'hAA);
    send_byte(8'h66); check("data_660", lane.data_out, 8'h66); check("vld_660", {7'd0, lane.valid_out}, 8'd1);
    send_byte(8'h66); check("data_661", lane.data_out, 8'h66);

    // Idle COM inside the data stream
    send_byte(8'h11); check("idle_d11", lane.data_out, 8'h11);
    send_byte(COM);
    check("idle_com", {6'd0, lane.com_out, lane.valid_out}, 8'b10);
    check("idle_data_bc", lane.data_out, 8'hBC);
    send_byte(8'h22); check("idle_d22", lane.data_out, 8'h22); check("vld_d22", {7'd0, lane.valid_out}, 8'd1);

    // Reset for one cycle in the middle of a data byte
    for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)), 1'b0);
    step(1'b0, 1'b1);
    check("midrst_data", lane.data_out, 8'h00);
    check("midrst_flags", {5'd0, lane.valid_out, lane.com_out, lane.active_out}, 8'd0);
    for (int i = 0; i < 3; i++) send_byte(COM);
    send_byte(8'h77);
    check("relock_needed", {6'd0, lane.valid_out, lane.active_out}, 8'd0);

    // Arbitrary bit offset ahead of the COMs
    do_reset(2);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(COM);
    send_byte(8'h5A);
    check("offset_data", lane.data_out, 8'h5A);
    check("offset_vld", {6'd0, lane.valid_out, lane.active_out}, 8'b11);

    // Broken alignment, then a clean lock
    do_reset(2);
    send_byte(COM); send_byte(COM); send_byte(8'h12);
    check("broken_inactive", {7'd0, lane.active_out}, 8'd0);
    for (int i = 0; i < 4; i++) send_byte(COM);
    send_byte(8'hC3);
    check("broken_c3", lane.data_out, 8'hC3);
    check("broken_vld", {7'd0, lane.valid_out}, 8'd1);

    // Randomized streams: junk, COM runs, payload with idles, occasional resets
    for (int seg = 0; seg < 150; seg++) begin
      int junk, ncom, nbytes;
      if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 2));
      junk = $urandom_range(0, 11);
      for (int i = 0; i < junk; i++) step(1'($urandom_range(0, 1)), 1'b0);
      ncom = $urandom_range(0, 6);
      for (int i = 0; i < ncom; i++) send_byte(COM);
      nbytes = $urandom_range(0, 6);
      for (int i = 0; i < nbytes; i++) begin
        if ($urandom_range(0, 4) == 0) send_byte(COM);
        else send_byte(8'($urandom));
      end
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 7)); i++) step(1'($urandom_range(0, 1)), 1'b0);
        step(1'b0, 1'b1);
      end
    end

    @(negedge clk_32f);
    @(posedge clk_32f);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
